// File: rtl/comb_lock_pkg.sv
// Shared definitions for the comb_lock keypad front end.
// Holds key codes, scanner and transmit state encodings, the passcode length,
// and small decode helpers used by the scanner.
package comb_lock_pkg;

  localparam int unsigned PASS_LEN = 4;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    ScScan,
    ScDebounce,
    ScWaitRelease
  } scan_state_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxSendEn,
    TxSendD1,
    TxSendD2,
    TxSendD3,
    TxSendD4
  } tx_state_e;

  // Index of the lowest-numbered low bit of an active-low vector (0 if none).
  function automatic logic [1:0] lowest_low(input logic [3:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!vec[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Key code at (row, col) of the 4x4 keypad.
  function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/comb_lock_keypad_tx_scanner.sv
// keypad_scanner: row scan, press/release debounce and key decode.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   col_in       - column sense, active-low, already synchronized
//   row_out      - row drive, one-hot active-low
//   key_valid    - one-cycle pulse per debounced press
//   key_code     - decoded key, valid with key_valid
module keypad_scanner
  import comb_lock_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned ScanW = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_CYCLES - 1);
  localparam logic [DebW-1:0]  DebMax   = DebW'(DEBOUNCE_CYCLES);

  scan_state_e      state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       col_pat_q, col_pat_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_pat_d  = col_pat_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    unique case (state_q)
      ScScan: begin
        if (col_in != 4'hF) begin
          // Row drive stays frozen from here until release completes.
          col_pat_d  = col_in;
          code_d     = key_decode(lowest_low(row_q), lowest_low(col_in));
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          state_d    = ScDebounce;
        end else if (scan_cnt_q == ScanLast) begin
          scan_cnt_d = '0;
          row_d      = {row_q[2:0], row_q[3]};
        end else begin
          scan_cnt_d = scan_cnt_q + ScanW'(1);
        end
      end
      ScDebounce: begin
        if (deb_cnt_q == DebMax) begin
          valid_d   = 1'b1;
          deb_cnt_d = '0;
          state_d   = ScWaitRelease;
        end else if (col_in == col_pat_q) begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end else begin
          deb_cnt_d = '0;
          state_d   = ScScan;
        end
      end
      ScWaitRelease: begin
        if (col_in != 4'hF) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebMax - DebW'(1)) begin
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          state_d    = ScScan;
        end else begin
          deb_cnt_d = deb_cnt_q + DebW'(1);
        end
      end
      default: state_d = ScScan;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ScScan;
      row_q      <= 4'b1110;
      col_pat_q  <= 4'hF;
      code_q     <= 4'h0;
      valid_q    <= 1'b0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_pat_q  <= col_pat_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  assign row_out   = row_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

// File: rtl/comb_lock_keypad_tx.sv
// comb_lock_keypad_tx: keypad entry buffer and transmitter for comb_lock.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   row_out       - keypad row drive, one-hot active-low
//   col_in        - keypad column sense, active-low
//   lock_busy     - comb_lock is in LOCK; blocks starting a burst
//   enter_button  - one-cycle start pulse to comb_lock
//   ip_pass       - BCD digit to comb_lock, one per cycle after enter
//   digit_count   - digits currently buffered (0-4)
//   tx_active     - high for the 5-cycle burst
module comb_lock_keypad_tx
  import comb_lock_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  input  logic       lock_busy,
  output logic       enter_button,
  output logic [3:0] ip_pass,
  output logic [2:0] digit_count,
  output logic       tx_active
);

  logic       key_valid;
  logic [3:0] key_code;

  keypad_scanner #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  tx_state_e  state_q, state_d;
  logic [3:0] buf_q [PASS_LEN];
  logic [3:0] buf_d [PASS_LEN];
  logic [2:0] count_q, count_d;
  logic       enter_q, enter_d;
  logic [3:0] pass_q, pass_d;
  logic       active_q, active_d;
  logic       buf_full;

  assign buf_full = (count_q == 3'(PASS_LEN));

  // Outputs are computed alongside the next state so they appear in the cycle
  // that the new state occupies, giving comb_lock its enter-then-digits cadence.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    count_d  = count_q;
    enter_d  = 1'b0;
    pass_d   = 4'h0;
    active_d = 1'b0;
    unique case (state_q)
      TxIdle: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (!buf_full) begin
              buf_d[count_q[1:0]] = key_code;
              count_d             = count_q + 3'd1;
            end
          end else if (key_code == KEY_STAR) begin
            for (int i = 0; i < PASS_LEN; i++) buf_d[i] = 4'h0;
            count_d = 3'd0;
          end else if (key_code == KEY_HASH) begin
            if (!buf_full) begin
              for (int i = 0; i < PASS_LEN; i++) buf_d[i] = 4'h0;
              count_d = 3'd0;
            end else if (!lock_busy) begin
              state_d  = TxSendEn;
              enter_d  = 1'b1;
              active_d = 1'b1;
            end
          end
        end
      end
      TxSendEn: begin
        state_d  = TxSendD1;
        pass_d   = buf_q[0];
        active_d = 1'b1;
      end
      TxSendD1: begin
        state_d  = TxSendD2;
        pass_d   = buf_q[1];
        active_d = 1'b1;
      end
      TxSendD2: begin
        state_d  = TxSendD3;
        pass_d   = buf_q[2];
        active_d = 1'b1;
      end
      TxSendD3: begin
        state_d  = TxSendD4;
        pass_d   = buf_q[3];
        active_d = 1'b1;
      end
      TxSendD4: begin
        state_d = TxIdle;
        for (int i = 0; i < PASS_LEN; i++) buf_d[i] = 4'h0;
        count_d = 3'd0;
      end
      default: state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= TxIdle;
      for (int i = 0; i < PASS_LEN; i++) buf_q[i] <= 4'h0;
      count_q  <= 3'd0;
      enter_q  <= 1'b0;
      pass_q   <= 4'h0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      count_q  <= count_d;
      enter_q  <= enter_d;
      pass_q   <= pass_d;
      active_q <= active_d;
    end
  end

  assign enter_button = enter_q;
  assign ip_pass      = pass_q;
  assign digit_count  = count_q;
  assign tx_active    = active_q;

endmodule

// File: tb/tb_comb_lock_keypad_tx.sv
// Bench for comb_lock_keypad_tx: keypad model on row_out/col_in, a reference
// entry model that pushes expected bursts, and a monitor collecting sent digits.
module tb_comb_lock_keypad_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_out;
  logic [3:0] col_in;
  logic       lock_busy = 1'b0;
  logic       enter_button;
  logic [3:0] ip_pass;
  logic [2:0] digit_count;
  logic       tx_active;

  // Keypad model: pressed key pulls its column low while its row is driven.
  logic       key_down = 1'b0;
  logic       contact = 1'b1;
  logic [1:0] krow = 2'd0;
  logic [1:0] kcol = 2'd0;

  assign col_in = (key_down && contact && row_out[krow] == 1'b0) ? ~(4'b0001 << kcol) : 4'hF;

  comb_lock_keypad_tx #(
    .SCAN_CYCLES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_out     (row_out),
    .col_in      (col_in),
    .lock_busy   (lock_busy),
    .enter_button(enter_button),
    .ip_pass     (ip_pass),
    .digit_count (digit_count),
    .tx_active   (tx_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int enter_cnt = 0;
  int leak_cnt = 0;

  logic [3:0] exp_q[$];
  logic [3:0] rx_q[$];

  // Reference entry model.
  logic [3:0] mbuf [4];
  int         mcnt = 0;

  // Monitor: collects digits sent during the burst (tx_active without enter).
  always @(negedge clk) begin
    if (enter_button === 1'b1) enter_cnt++;
    if (tx_active === 1'b1 && enter_button === 1'b0) rx_q.push_back(ip_pass);
    if (ip_pass !== 4'h0 && ip_pass !== 4'hx && !(tx_active === 1'b1 && enter_button === 1'b0))
      leak_cnt++;
    if (enter_button === 1'b1 && tx_active !== 1'b1) leak_cnt++;
  end

  task automatic model_key(input logic [3:0] code);
    if (code <= 4'd9) begin
      if (mcnt < 4) begin
        mbuf[mcnt] = code;
        mcnt++;
      end
    end else if (code == 4'hE) begin
      mcnt = 0;
    end else if (code == 4'hF) begin
      if (mcnt == 4 && !lock_busy) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(mbuf[i]);
        mcnt = 0;
      end else if (mcnt < 4) begin
        mcnt = 0;
      end
    end
  endtask

  task automatic set_key(input logic [3:0] code);
    case (code)
      4'h1: begin krow = 2'd0; kcol = 2'd0; end
      4'h2: begin krow = 2'd0; kcol = 2'd1; end
      4'h3: begin krow = 2'd0; kcol = 2'd2; end
      4'hA: begin krow = 2'd0; kcol = 2'd3; end
      4'h4: begin krow = 2'd1; kcol = 2'd0; end
      4'h5: begin krow = 2'd1; kcol = 2'd1; end
      4'h6: begin krow = 2'd1; kcol = 2'd2; end
      4'hB: begin krow = 2'd1; kcol = 2'd3; end
      4'h7: begin krow = 2'd2; kcol = 2'd0; end
      4'h8: begin krow = 2'd2; kcol = 2'd1; end
      4'h9: begin krow = 2'd2; kcol = 2'd2; end
      4'hC: begin krow = 2'd2; kcol = 2'd3; end
      4'hE: begin krow = 2'd3; kcol = 2'd0; end
      4'h0: begin krow = 2'd3; kcol = 2'd1; end
      4'hF: begin krow = 2'd3; kcol = 2'd2; end
      default: begin krow = 2'd3; kcol = 2'd3; end
    endcase
  endtask

  // Press, hold long enough for scan + debounce + burst, then release.
  task automatic press_key(input logic [3:0] code);
    @(negedge clk);
    set_key(code);
    contact  = 1'b1;
    key_down = 1'b1;
    repeat (40) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    model_key(code);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (row_out !== 4'b1110) begin
      n_fail++; $display("FAIL reset_row_out: got %b want %b", row_out, 4'b1110);
    end
    n_checks++;
    if ({enter_button, ip_pass, digit_count, tx_active} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got enter=%b ip=%h cnt=%0d tx=%b want all 0",
               enter_button, ip_pass, digit_count, tx_active);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_burst;
    logic [3:0] digs [4];
    logic [3:0] e, r;
    int         ent0;
    digs[0] = 4'd1; digs[1] = 4'd5; digs[2] = 4'd3; digs[3] = 4'd7;
    ent0 = enter_cnt;
    for (int i = 0; i < 4; i++) begin
      press_key(digs[i]);
      n_checks++;
      if (digit_count !== 3'(mcnt)) begin
        n_fail++; $display("FAIL t1_count_%0d: got %0d want %0d", i, digit_count, mcnt);
      end
    end
    press_key(4'hF);
    n_checks++;
    if (enter_cnt - ent0 != 1) begin
      n_fail++; $display("FAIL t1_enter_pulses: got %0d want 1", enter_cnt - ent0);
    end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL t1_burst_len: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL t1_digit: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
    n_checks++;
    if (digit_count !== 3'd0 || tx_active !== 1'b0) begin
      n_fail++; $display("FAIL t1_after: got cnt=%0d tx=%b want 0 0", digit_count, tx_active);
    end
  endtask

  task automatic test_bounce;
    @(negedge clk);
    set_key(4'd5);
    key_down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      contact = 1'b1;
      repeat (2) @(negedge clk);
      contact = 1'b0;
      repeat (2) @(negedge clk);
    end
    n_checks++;
    if (digit_count !== 3'd0) begin
      n_fail++; $display("FAIL t2_during_bounce: got %0d want 0", digit_count);
    end
    contact = 1'b1;
    repeat (40) @(negedge clk);
    key_down = 1'b0;
    repeat (30) @(negedge clk);
    model_key(4'd5);
    n_checks++;
    if (digit_count !== 3'd1) begin
      n_fail++; $display("FAIL t2_single_digit: got %0d want 1", digit_count);
    end
    press_key(4'hE);
    n_checks++;
    if (digit_count !== 3'd0) begin
      n_fail++; $display("FAIL t2_star_clear: got %0d want 0", digit_count);
    end
  endtask

  task automatic test_overflow_star;
    logic [3:0] seq [9];
    logic [3:0] e, r;
    seq[0] = 4'd9; seq[1] = 4'd8; seq[2] = 4'hE; seq[3] = 4'd2; seq[4] = 4'd4;
    seq[5] = 4'd6; seq[6] = 4'd0; seq[7] = 4'd1; seq[8] = 4'hA;
    for (int i = 0; i < 9; i++) press_key(seq[i]);
    n_checks++;
    if (digit_count !== 3'd4) begin
      n_fail++; $display("FAIL t3_count_full: got %0d want 4", digit_count);
    end
    press_key(4'hF);
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL t3_burst_len: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL t3_digit: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_short_hash;
    int ent0;
    ent0 = enter_cnt;
    press_key(4'd1);
    press_key(4'd5);
    n_checks++;
    if (digit_count !== 3'd2) begin
      n_fail++; $display("FAIL t4_count_two: got %0d want 2", digit_count);
    end
    press_key(4'hF);
    n_checks++;
    if (enter_cnt != ent0 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL t4_no_tx: got enters=%0d digits=%0d want 0 0",
                         enter_cnt - ent0, rx_q.size());
    end
    n_checks++;
    if (digit_count !== 3'd0) begin
      n_fail++; $display("FAIL t4_cleared: got %0d want 0", digit_count);
    end
  endtask

  task automatic test_lock_busy;
    logic [3:0] e, r;
    int         ent0;
    press_key(4'd2); press_key(4'd0); press_key(4'd2); press_key(4'd5);
    ent0 = enter_cnt;
    lock_busy = 1'b1;
    press_key(4'hF);
    n_checks++;
    if (enter_cnt != ent0 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL t5_busy_blocks: got enters=%0d digits=%0d want 0 0",
                         enter_cnt - ent0, rx_q.size());
    end
    n_checks++;
    if (digit_count !== 3'd4) begin
      n_fail++; $display("FAIL t5_busy_keeps: got %0d want 4", digit_count);
    end
    lock_busy = 1'b0;
    press_key(4'hF);
    n_checks++;
    if (rx_q.size() != exp_q.size() || enter_cnt - ent0 != 1) begin
      n_fail++; $display("FAIL t5_burst: got digits=%0d enters=%0d want %0d 1",
                         rx_q.size(), enter_cnt - ent0, exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL t5_digit: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_reset_mid_burst;
    logic [3:0] e, r;
    bit         seen;
    press_key(4'd8); press_key(4'd6); press_key(4'd4); press_key(4'd2);
    @(negedge clk);
    set_key(4'hF);
    key_down = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (enter_button === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL t6_enter_seen: got none within 60 cycles want pulse");
    end
    // Two more cycles show digits 1 and 2; reset lands during the SEND_D2 cycle.
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    key_down = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({enter_button, ip_pass, digit_count, tx_active} !== 9'd0 || row_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL t6_reset_outputs: got enter=%b ip=%h cnt=%0d tx=%b row=%b want 0 0 0 0 1110",
               enter_button, ip_pass, digit_count, tx_active, row_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    mcnt = 0;
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd6);
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL t6_partial_len: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL t6_partial_digit: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
    press_key(4'd3); press_key(4'd1); press_key(4'd4); press_key(4'd1);
    press_key(4'hF);
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL t6_fresh_len: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL t6_fresh_digit: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_bounce();
    test_overflow_star();
    test_short_hash();
    test_lock_busy();
    test_reset_mid_burst();
    n_checks++;
    if (leak_cnt != 0) begin
      n_fail++; $display("FAIL idle_ip_pass_leak: got %0d bad cycles want 0", leak_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/comb_lock_keypad_tx.md
# comb_lock_keypad_tx

Keypad front end and transmitter for `comb_lock`.
- Scans a 4x4 matrix keypad, debounces presses and decodes them to BCD.
- Buffers a 4-digit entry.
- On `#`, replays the entry on the `enter_button`/`ip_pass` interface with the exact cycle timing `comb_lock` samples: enter, then one digit per cycle for CHECK_1..CHECK_4.
- Its `lock_busy` input connects to `comb_lock.lock`.

## Interface
Parameters:
- `SCAN_CYCLES`, default 1000: cycles each row stays driven while scanning.
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required for press and for release (10 ms at 10 MHz).

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `row_out`, out, 4: keypad row drive, one-hot active-low.
- `col_in`, in, 4: keypad column sense, active-low, already synchronized externally.
- `lock_busy`, in, 1: high while `comb_lock` is in LOCK; blocks transmission.
- `enter_button`, out, 1: one-cycle start pulse to `comb_lock`.
- `ip_pass`, out, 4: BCD digit to `comb_lock`.
- `digit_count`, out, 3: digits currently buffered (0-4).
- `tx_active`, out, 1: high during the 5-cycle transmit burst.

## Operation
Key map (row, col):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: * 0 # D
- A-D are decoded but ignored.

Scanner FSM (sub-module):
- SCAN
  - Rotate the active row r0→r1→r2→r3→r0 every `SCAN_CYCLES`.
  - If any `col_in` bit is low: latch row and the lowest-index low column, freeze `row_out`, go to DEBOUNCE.
- DEBOUNCE
  - Count cycles with `col_in` equal to the latched pattern.
  - Any mismatch: back to SCAN, counter cleared.
  - When the count reaches `DEBOUNCE_CYCLES`: pulse `key_valid` for 1 cycle with `key_code`, go to WAIT_RELEASE.
- WAIT_RELEASE
  - Require `col_in == 4'hF` for `DEBOUNCE_CYCLES` consecutive cycles, then go to SCAN. Any low bit restarts the count.
  - A held key produces exactly one `key_valid`.

Entry/transmit FSM:
- IDLE, accepting keys:
  - Digit with `digit_count < 4`: store at index `digit_count`, increment.
  - Digit with `digit_count == 4`: ignored; no overwrite.
  - `*`: clear buffer, `digit_count = 0`.
  - `#` with `digit_count == 4` and `lock_busy == 0`: go to SEND_EN.
  - `#` with `digit_count < 4`: clear buffer, no transmit.
  - `#` with `lock_busy == 1`: ignored, buffer kept.
- SEND_EN: `enter_button = 1`, `ip_pass = 0`.
- SEND_D1..SEND_D4: `ip_pass` = digit 1..4, `enter_button = 0`.
- After SEND_D4: clear buffer, return to IDLE.
- `key_valid` arriving in any SEND state is dropped.
- All 4 digits are always sent; `comb_lock` aborts to DENY on its own mismatch, and the trailing digits are harmless because its IDLE waits for `enter_button`.

## Timing
- Reset (`rst_n` low at a rising edge), applied on that edge:
  - `row_out = 4'b1110`
  - `enter_button = 0`, `ip_pass = 0`, `digit_count = 0`, `tx_active = 0`
  - all FSMs to SCAN/IDLE, all counters 0
- Reset mid-burst aborts the burst on that edge; no further `enter_button` or digits are emitted.
- All outputs are registered.
- Press to `key_valid`: `DEBOUNCE_CYCLES` + 1 cycles after the first sampled low column.
- `key_valid` to buffer update: 1 cycle.
- `#` accepted at edge T:
  - cycle T+1: `enter_button = 1`
  - cycles T+2..T+5: digits 1..4
  - cycle T+6: `ip_pass = 0`, `digit_count = 0`
  - `tx_active` is high for cycles T+1..T+5.
- This matches `comb_lock`: IDLE samples enter at T+1, CHECK_1..CHECK_4 sample digits at T+2..T+5.
- `lock_busy` is sampled only on the `#` acceptance cycle; it does not abort a burst in progress.

## Structure
- Shared package `comb_lock_pkg` holds:
  - key codes: `KEY_STAR = 4'hE`, `KEY_HASH = 4'hF`, `KEY_A..KEY_D = 4'hA..4'hD`
  - the scanner and transmit state encodings
  - `PASS_LEN = 4`
- One sub-module, `keypad_scanner`, containing the scanner FSM and debounce counters. Its outputs are `key_valid` and `key_code[3:0]`.
- The top level holds the digit buffer (4x4 bits) and the transmit FSM.

## Test plan
Bench parameters: `SCAN_CYCLES = 2`, `DEBOUNCE_CYCLES = 4`; keypad model attached to `row_out`/`col_in`.
1. Press 1, 5, 3, 7, then `#` (`lock_busy = 0`) → `enter_button` pulse, then `ip_pass` = 1, 5, 3, 7 on the 4 following cycles; `digit_count` returns to 0; wired to `comb_lock`, `grant` = 1.
2. Bouncing press: `col_in` toggles low/high every 2 cycles for 10 cycles, then holds low 8 cycles → exactly one `key_valid`, and none during the bounce. A held key produces a single digit.
3. Press 9, 8, `*`, then 2, 4, 6, 0, 1, `#` → 5th digit ignored; burst sends 2, 4, 6, 0.
4. Press 1, 5, `#` → no `enter_button`; `digit_count` = 0.
5. Four digits, `lock_busy = 1`, `#` → no burst, `digit_count` stays 4. Drop `lock_busy`, press `#` → burst sent.
6. Assert `rst_n = 0` during the SEND_D2 cycle → next edge all outputs 0, no further digits; a fresh entry afterwards transmits normally.
